polar_enc_pipe: RTL and testbench

- Parametrised, fully pipelined polar encoder: computes x = u·F^{⊗n}, N = 2^LOG2N, one codeword per cycle at full throughput.
- Successor to the fixed 1024-bit, start/done-pulsed encoder. Adds:
  - configurable N and butterfly stages per register;
  - valid/ready backpressure;
  - per-transaction frozen-bit masking;
  - per-transaction natural or bit-reversed output order;
  - pipeline occupancy count.
- Sits between the rate-matching/info-bit mapper (upstream) and the modulator buffer (downstream).

---
 rtl/polar_enc_pipe.sv | 136 +++++++++++++
 tb/tb_polar_enc_pipe.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_enc_pipe.sv
`default_nettype none
// ============================================================================
// polar_enc_pipe : pipelined polar encoder x = u * F^(xn) with valid/ready,
//                  frozen-bit masking and optional bit-reversed output order.
// Rev 1.0
// ============================================================================
module polar_enc_pipe #(
  parameter  int LOG2N       = 10,
  parameter  int STG_PER_REG = 2,
  localparam int N           = 1 << LOG2N,
  localparam int LAT         = (LOG2N + STG_PER_REG - 1) / STG_PER_REG,
  localparam int CW          = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_u,
  input  logic [N-1:0]  in_frz_mask,
  input  logic          in_bitrev,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_x,
  output logic [CW-1:0] pipe_cnt
);

  // Applies butterfly stages lo..hi-1; each stage folds the upper partner into the lower one.
  function automatic logic [N-1:0] bfly(input logic [N-1:0] v_in, input int lo, input int hi);
    logic [N-1:0]     v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    v = v_in;
    for (int s = 0; s < LOG2N; s++) begin
      if (s >= lo && s < hi) begin
        for (int k = 0; k < N / 2; k++) begin
          a    = LOG2N'(((k >> s) << (s + 1)) | (k & ((1 << s) - 1)));
          b    = a | LOG2N'(1 << s);
          v[a] = v[a] ^ v[b];
        end
      end
    end
    return v;
  endfunction

  function automatic int bitrev(input int idx);
    int r;
    r = 0;
    for (int k = 0; k < LOG2N; k++) r = (r << 1) | ((idx >> k) & 1);
    return r;
  endfunction

  logic                  advance;
  logic                  accept;
  logic                  leave;
  logic [LAT-1:0][N-1:0] data_w;
  logic [LAT-1:0]        vld_w;
  logic [LAT-1:0]        brev_w;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  assign out_valid = vld_w[LAT-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid & advance;
  assign leave     = out_valid & out_ready;

  for (genvar r = 0; r < LAT; r++) begin : g_reg
    localparam int LO = r * STG_PER_REG;
    localparam int HI = ((r + 1) * STG_PER_REG < LOG2N) ? (r + 1) * STG_PER_REG : LOG2N;

    logic [N-1:0] d_in;
    logic         v_in;
    logic         b_in;
    logic [N-1:0] data_d;
    logic [N-1:0] data_q;
    logic         valid_q;
    logic         brev_q;

    if (r == 0) begin : g_head
      assign d_in = in_u & ~in_frz_mask;
      assign v_in = accept;
      assign b_in = in_bitrev;
    end else begin : g_body
      assign d_in = data_w[r-1];
      assign v_in = vld_w[r-1];
      assign b_in = brev_w[r-1];
    end

    assign data_d = bfly(d_in, LO, HI);

    // Data only loads behind a valid word, so bubbles never disturb out_x.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        brev_q  <= 1'b0;
      end else if (advance) begin
        valid_q <= v_in;
        if (v_in) begin
          data_q <= data_d;
          brev_q <= b_in;
        end
      end
    end

    assign data_w[r] = data_q;
    assign vld_w[r]  = valid_q;
    assign brev_w[r] = brev_q;
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    localparam int RI = bitrev(i);
    assign out_x[i] = brev_w[LAT-1] ? data_w[LAT-1][RI] : data_w[LAT-1][i];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !leave) begin
      cnt_d = cnt_q + CW'(1);
    end else if (leave && !accept) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pipe_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_polar_enc_pipe.sv
`default_nettype none
// tb_polar_enc_pipe: directed and randomized checks of polar_enc_pipe in three
// configurations (LOG2N/STG_PER_REG = 3/1, 10/2, 5/2) against a subset-XOR model.
module tb_polar_enc_pipe;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic          a_in_valid, a_in_ready, a_br, a_out_valid, a_out_ready;
  logic [7:0]    a_in_u, a_frz, a_out_x;
  logic [1:0]    a_cnt;
  logic          b_in_valid, b_in_ready, b_br, b_out_valid, b_out_ready;
  logic [1023:0] b_in_u, b_frz, b_out_x;
  logic [2:0]    b_cnt;
  logic          c_in_valid, c_in_ready, c_br, c_out_valid, c_out_ready;
  logic [31:0]   c_in_u, c_frz, c_out_x;
  logic [1:0]    c_cnt;

  polar_enc_pipe #(.LOG2N(3), .STG_PER_REG(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_u(a_in_u),
    .in_frz_mask(a_frz), .in_bitrev(a_br), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_x(a_out_x), .pipe_cnt(a_cnt));

  polar_enc_pipe #(.LOG2N(10), .STG_PER_REG(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_u(b_in_u),
    .in_frz_mask(b_frz), .in_bitrev(b_br), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_x(b_out_x), .pipe_cnt(b_cnt));

  polar_enc_pipe #(.LOG2N(5), .STG_PER_REG(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_u(c_in_u),
    .in_frz_mask(c_frz), .in_bitrev(c_br), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_x(c_out_x), .pipe_cnt(c_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // x[i] = XOR of u'[j] over every j whose bit set contains i's, then optional index reversal.
  function automatic logic [1023:0] ref_enc(input logic [1023:0] u, input logic [1023:0] m,
                                            input logic br, input int lg);
    int n;
    int r;
    logic b;
    logic [1023:0] up, x, y;
    n  = 1 << lg;
    up = u & ~m;
    x  = '0;
    y  = '0;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      for (int j = i; j < n; j = (j + 1) | i) b = b ^ up[j];
      x[i] = b;
    end
    for (int i = 0; i < n; i++) begin
      r = 0;
      for (int k = 0; k < lg; k++) r = r * 2 + ((i >> k) & 1);
      y[i] = br ? x[r] : x[i];
    end
    return y;
  endfunction

  function automatic logic [7:0] ref8(input logic [7:0] u, input logic [7:0] m, input logic br);
    logic [1023:0] t;
    t = ref_enc({1016'b0, u}, {1016'b0, m}, br, 3);
    return t[7:0];
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] u, input logic [31:0] m, input logic br);
    logic [1023:0] t;
    t = ref_enc({992'b0, u}, {992'b0, m}, br, 5);
    return t[31:0];
  endfunction

  // ---------------- config A bookkeeping (LAT = 3) ----------------
  logic [7:0] aq[$];
  int         at[$];
  int         acnt = 0;
  int         acyc = 0;

  task automatic a_drive(input logic v, input logic [7:0] u, input logic [7:0] m, input logic br,
                         input logic ordy, output logic acc, output logic lv);
    a_in_valid  = v;
    a_in_u      = u;
    a_frz       = m;
    a_br        = br;
    a_out_ready = ordy;
    #1;
    acc = a_in_valid & a_in_ready;
    lv  = a_out_valid & a_out_ready;
  endtask

  task automatic a_book(input logic acc, input logic lv, input logic [7:0] e);
    if (lv && aq.size() > 0) begin
      void'(aq.pop_front());
      void'(at.pop_front());
    end
    if (acc) begin
      aq.push_back(e);
      at.push_back(acyc);
    end
    acnt = acnt + (acc ? 1 : 0) - (lv ? 1 : 0);
    acyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic a_run(input string name, input logic [7:0] tu[$], input logic [7:0] tm[$],
                       input logic tbr[$], input logic [7:0] te[$], output int maxcnt);
    logic acc, lv;
    int idx, guard;
    idx    = 0;
    guard  = 0;
    maxcnt = 0;
    while ((idx < tu.size() || aq.size() > 0) && guard < 64) begin
      if (idx < tu.size()) a_drive(1'b1, tu[idx], tm[idx], tbr[idx], 1'b1, acc, lv);
      else a_drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, lv);
      if (lv) begin
        tests_run++;
        if (aq.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_spurious got out_x=%h required no output", name, a_out_x);
        end else if (a_out_x !== aq[0] || acyc - at[0] != 3) begin
          tests_failed++;
          $display("FAIL %s_out got %h lat %0d required %h lat 3", name, a_out_x, acyc - at[0], aq[0]);
        end
      end
      tests_run++;
      if (a_cnt !== 2'(acnt)) begin
        tests_failed++;
        $display("FAIL %s_cnt got %0d required %0d", name, a_cnt, acnt);
      end
      if (int'(a_cnt) > maxcnt) maxcnt = int'(a_cnt);
      a_book(acc, lv, (idx < tu.size()) ? te[idx] : 8'h00);
      if (acc) idx++;
      guard++;
    end
    tests_run++;
    if (idx != tu.size() || aq.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout sent %0d of %0d pending %0d required 0", name, idx, tu.size(), aq.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    a_in_u = 8'hFF; a_frz = 8'h00; a_br = 1'b0;
    b_in_u = '1; b_frz = '0; b_br = 1'b0;
    c_in_u = '1; c_frz = '0; c_br = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_x !== 8'h00 || a_cnt !== 2'd0 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_a got v=%b x=%h cnt=%0d rdy=%b required 0/00/0/1", a_out_valid, a_out_x, a_cnt, a_in_ready);
    end
    tests_run++;
    if (b_out_valid !== 1'b0 || b_out_x !== '0 || b_cnt !== 3'd0 || b_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_b got v=%b x_low=%h cnt=%0d rdy=%b required 0/0/0/1", b_out_valid, b_out_x[63:0], b_cnt, b_in_ready);
    end
    tests_run++;
    if (c_out_valid !== 1'b0 || c_out_x !== 32'h0 || c_cnt !== 2'd0 || c_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_c got v=%b x=%h cnt=%0d rdy=%b required 0/0/0/1", c_out_valid, c_out_x, c_cnt, c_in_ready);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] tu[$], tm[$], te[$];
    logic tbr[$];
    logic [7:0] u;
    logic br;
    int mx;
    tu  = '{8'h01, 8'h80, 8'h02, 8'h02};
    tbr = '{1'b0, 1'b0, 1'b0, 1'b1};
    te  = '{8'h01, 8'hFF, 8'h03, 8'h11};
    tm  = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) begin
      u  = 8'($urandom);
      br = 1'($urandom);
      tu.push_back(u);
      tbr.push_back(br);
      tm.push_back(8'h00);
      te.push_back(ref8(u, 8'h00, br));
    end
    a_run("stream", tu, tm, tbr, te, mx);
    tests_run++;
    if (mx != 3) begin
      tests_failed++;
      $display("FAIL stream_cnt_peak got %0d required 3", mx);
    end
  endtask

  task automatic test_mask();
    logic [7:0] tu[$], tm[$], te[$];
    logic tbr[$];
    int mx;
    tu  = '{8'hFF, 8'hFF};
    tm  = '{8'h7F, 8'hFF};
    tbr = '{1'b0, 1'b0};
    te  = '{8'hFF, 8'h00};
    a_run("mask", tu, tm, tbr, te, mx);
  endtask

  task automatic test_backpressure();
    logic acc, lv;
    logic [7:0] u;
    int guard;
    for (int k = 0; k < 3; k++) begin
      u = 8'($urandom);
      a_drive(1'b1, u, 8'h00, 1'b0, 1'b1, acc, lv);
      tests_run++;
      if (acc !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_fill word %0d got accept=%b required 1", k, acc);
      end
      a_book(acc, lv, ref8(u, 8'h00, 1'b0));
    end
    for (int k = 0; k < 5; k++) begin
      a_drive(1'b1, 8'($urandom), 8'h00, 1'b0, 1'b0, acc, lv);
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_x !== aq[0] || a_in_ready !== 1'b0 || a_cnt !== 2'd3) begin
        tests_failed++;
        $display("FAIL bp_stall cyc %0d got v=%b x=%h rdy=%b cnt=%0d required 1/%h/0/3",
                 k, a_out_valid, a_out_x, a_in_ready, a_cnt, aq[0]);
      end
      a_book(acc, lv, 8'h00);
    end
    guard = 0;
    while (aq.size() > 0 && guard < 10) begin
      a_drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, lv);
      tests_run++;
      if (lv !== 1'b1 || a_out_x !== aq[0] || a_cnt !== 2'(acnt)) begin
        tests_failed++;
        $display("FAIL bp_release got v=%b x=%h cnt=%0d required 1/%h/%0d", a_out_valid, a_out_x, a_cnt, aq[0], acnt);
      end
      a_book(acc, lv, 8'h00);
      guard++;
    end
    tests_run++;
    if (aq.size() != 0 || a_cnt !== 2'd0 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain got pending=%0d cnt=%0d v=%b required 0/0/0", aq.size(), a_cnt, a_out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, lv;
    logic [7:0] u;
    for (int k = 0; k < 2; k++) begin
      u = 8'($urandom) | 8'h80;
      a_drive(1'b1, u, 8'h00, 1'b0, 1'b1, acc, lv);
      a_book(acc, lv, ref8(u, 8'h00, 1'b0));
    end
    rst = 1'b1;
    a_drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, acc, lv);
    @(posedge clk);
    #1;
    rst = 1'b0;
    aq.delete();
    at.delete();
    acnt = 0;
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_x !== 8'h00 || a_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid got v=%b x=%h cnt=%0d required 0/00/0", a_out_valid, a_out_x, a_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      a_drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, lv);
      tests_run++;
      if (a_out_valid !== 1'b0 || a_out_x !== 8'h00 || a_cnt !== 2'd0) begin
        tests_failed++;
        $display("FAIL rst_stale cyc %0d got v=%b x=%h cnt=%0d required 0/00/0", k, a_out_valid, a_out_x, a_cnt);
      end
      a_book(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic b_drive(input logic v, input logic [1023:0] u, input logic [1023:0] m, input logic br,
                         input logic ordy, output logic acc, output logic lv);
    b_in_valid  = v;
    b_in_u      = u;
    b_frz       = m;
    b_br        = br;
    b_out_ready = ordy;
    #1;
    acc = b_in_valid & b_in_ready;
    lv  = b_out_valid & b_out_ready;
  endtask

  task automatic test_latency_default();
    logic acc, lv;
    logic [1023:0] u, m, e;
    logic br;
    int lat;
    for (int k = 0; k < 32; k++) begin
      u[k*32 +: 32] = $urandom;
      m[k*32 +: 32] = $urandom & $urandom;
    end
    br = 1'($urandom);
    e  = ref_enc(u, m, br, 10);
    b_drive(1'b1, u, m, br, 1'b1, acc, lv);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_accept got %b required 1", acc);
    end
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      b_drive(1'b0, '0, '0, 1'b0, 1'b1, acc, lv);
      if (lv) begin
        lat = k;
        tests_run++;
        if (b_out_x !== e) begin
          tests_failed++;
          $display("FAIL lat_data got[127:0]=%h required[127:0]=%h", b_out_x[127:0], e[127:0]);
        end
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (lat != 5) begin
      tests_failed++;
      $display("FAIL lat_default got %0d required 5", lat);
    end
  endtask

  task automatic test_random_default();
    logic [1023:0] bq[$];
    logic [1023:0] pu, pm, prev_x;
    logic pbr, acc, lv, v, ordy, prev_stall, have;
    int sent, cyc, cnt_m, nbad;
    sent = 0; cyc = 0; cnt_m = 0;
    prev_stall = 1'b0; have = 1'b0;
    prev_x = '0; pu = '0; pm = '0; pbr = 1'b0;
    while ((sent < 1000 || bq.size() > 0) && cyc < 20000) begin
      if (sent < 1000 && !have) begin
        for (int k = 0; k < 32; k++) begin
          pu[k*32 +: 32] = $urandom;
          pm[k*32 +: 32] = $urandom & $urandom;
        end
        pbr  = 1'($urandom);
        have = 1'b1;
      end
      v    = have && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      b_drive(v, pu, pm, pbr, ordy, acc, lv);
      if (prev_stall) begin
        tests_run++;
        if (b_out_valid !== 1'b1 || b_out_x !== prev_x) begin
          tests_failed++;
          $display("FAIL rand_hold cyc %0d got v=%b x[63:0]=%h required 1/%h", cyc, b_out_valid, b_out_x[63:0], prev_x[63:0]);
        end
      end
      if (lv) begin
        tests_run++;
        if (bq.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_spurious cyc %0d got output required none", cyc);
        end else if (b_out_x !== bq[0]) begin
          tests_failed++;
          nbad = $countones(b_out_x ^ bq[0]);
          $display("FAIL rand_data cyc %0d got[127:0]=%h required[127:0]=%h (%0d bits differ)",
                   cyc, b_out_x[127:0], bq[0][127:0], nbad);
        end
      end
      tests_run++;
      if (b_cnt !== 3'(cnt_m)) begin
        tests_failed++;
        $display("FAIL rand_cnt cyc %0d got %0d required %0d", cyc, b_cnt, cnt_m);
      end
      prev_stall = b_out_valid && !ordy;
      prev_x     = b_out_x;
      if (lv && bq.size() > 0) void'(bq.pop_front());
      if (acc) begin
        bq.push_back(ref_enc(pu, pm, pbr, 10));
        sent++;
        have = 1'b0;
      end
      cnt_m = cnt_m + (acc ? 1 : 0) - (lv ? 1 : 0);
      cyc++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (sent != 1000 || bq.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain got sent=%0d pending=%0d required 1000/0", sent, bq.size());
    end
  endtask

  task automatic test_odd_grouping();
    logic [31:0] cq[$];
    int ct[$];
    logic [31:0] u, m;
    logic br, acc, lv;
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while ((idx < 8 || cq.size() > 0) && cyc < 64) begin
      if (idx == 0) begin
        u = 32'h8000_0000; m = 32'h0; br = 1'b0;
      end else begin
        u = $urandom; m = $urandom & $urandom; br = 1'($urandom);
      end
      c_in_valid  = (idx < 8);
      c_in_u      = u;
      c_frz       = m;
      c_br        = br;
      c_out_ready = 1'b1;
      #1;
      acc = c_in_valid & c_in_ready;
      lv  = c_out_valid & c_out_ready;
      if (lv) begin
        tests_run++;
        if (cq.size() == 0) begin
          tests_failed++;
          $display("FAIL odd_spurious got %h required none", c_out_x);
        end else if (c_out_x !== cq[0] || cyc - ct[0] != 3) begin
          tests_failed++;
          $display("FAIL odd_out got %h lat %0d required %h lat 3", c_out_x, cyc - ct[0], cq[0]);
        end
        if (cq.size() > 0) begin
          void'(cq.pop_front());
          void'(ct.pop_front());
        end
      end
      if (acc) begin
        cq.push_back((idx == 0) ? 32'hFFFF_FFFF : ref32(u, m, br));
        ct.push_back(cyc);
        idx++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    c_in_valid = 1'b0;
    tests_run++;
    if (idx != 8 || cq.size() != 0) begin
      tests_failed++;
      $display("FAIL odd_timeout got sent=%0d pending=%0d required 8/0", idx, cq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_u = '0; a_frz = '0; a_br = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_u = '0; b_frz = '0; b_br = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_u = '0; c_frz = '0; c_br = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_mask();
    test_backpressure();
    test_reset_midflight();
    test_latency_default();
    test_random_default();
    test_odd_grouping();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
